psum_drain_accumulator: RTL

- Consumes the registered per-column partial sums produced by the systolic array top each cycle.
- Accumulates them over a programmed number of beats (K-tiles) into ARRAY_SIZE wide accumulators.
- Streams the final column results out one column per cycle over a valid/ready interface.
- Sits between the array top's psum outputs and the output buffer/writeback path, and provides backpressure to the array sequencer via psum_ready.

---
 rtl/psum_drain_if.sv | 34 +++
 rtl/psum_drain_accumulator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/psum_drain_if.sv
// Handshake bundle between the psum producer / sequencer and the drain accumulator.
// The block uses the slave modport; the driving side (array sequencer, writeback) uses master.
interface psum_drain_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int COL_WIDTH  = 13,
  parameter int ACC_WIDTH  = 64,
  parameter int CNT_WIDTH  = 16
);
  localparam int COL_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  logic                              start;
  logic [CNT_WIDTH-1:0]              acc_count;
  logic                              signed_mode;
  logic                              psum_valid;
  logic                              psum_ready;
  logic [ARRAY_SIZE*COL_WIDTH*4-1:0] psums;
  logic                              out_valid;
  logic                              out_ready;
  logic [ACC_WIDTH-1:0]              out_data;
  logic [COL_W-1:0]                  out_col;
  logic                              out_last;
  logic                              busy;
  logic                              done;

  modport slave (
    input  start, acc_count, signed_mode, psum_valid, psums, out_ready,
    output psum_ready, out_valid, out_data, out_col, out_last, busy, done
  );

  modport master (
    output start, acc_count, signed_mode, psum_valid, psums, out_ready,
    input  psum_ready, out_valid, out_data, out_col, out_last, busy, done
  );
endinterface

// File: rtl/psum_drain_accumulator.sv
// Accumulates per-column psum beats over acc_count K-tiles, then drains one column per cycle.
// Define PSUM_ACC_SAT_EN to make each accumulate saturate (sticky until next start) instead of wrap.
//
// state | meaning
// IDLE  | waiting for start with non-zero acc_count
// ACCUM | accepting psum beats until acc_count beats are summed
// DRAIN | presenting one column result per out handshake
module psum_drain_accumulator #(
  parameter int ARRAY_SIZE = 8,
  parameter int COL_WIDTH  = 13,
  parameter int ACC_WIDTH  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         rst,
  psum_drain_if.slave  bus
);
  localparam int LANE_W = COL_WIDTH * 4;
  localparam int COL_W  = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ARRAY_SIZE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]           state;
  logic [ACC_WIDTH-1:0] acc      [ARRAY_SIZE];
  logic [ACC_WIDTH-1:0] acc_next [ARRAY_SIZE];
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 signed_q;
  logic [COL_W-1:0]     col;
  logic [COL_W-1:0]     col_nxt;

  logic                 psum_ready_q;
  logic                 out_valid_q;
  logic [ACC_WIDTH-1:0] out_data_q;
  logic [COL_W-1:0]     out_col_q;
  logic                 out_last_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 beat_acc;
  logic                 last_beat;

`ifdef PSUM_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ARRAY_SIZE-1:0] sat_q;
  logic [ARRAY_SIZE-1:0] sat_next;
`endif

  for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
    logic [LANE_W-1:0]    lane;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] wsum;
    assign lane = bus.psums[c*LANE_W +: LANE_W];
    assign ext  = signed_q ? ACC_WIDTH'($signed(lane)) : ACC_WIDTH'(lane);
    assign wsum = acc[c] + ext;
`ifdef PSUM_ACC_SAT_EN
    logic                 ovf_s;
    logic                 ovf_u;
    logic                 sat_hit;
    logic [ACC_WIDTH-1:0] sat_val;
    // Signed overflow: operands agree in sign and the sum does not.
    assign ovf_s   = (acc[c][ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                     (wsum[ACC_WIDTH-1] != acc[c][ACC_WIDTH-1]);
    assign ovf_u   = (wsum < acc[c]);
    assign sat_hit = signed_q ? ovf_s : ovf_u;
    assign sat_val = signed_q ? (acc[c][ACC_WIDTH-1] ? SMIN : SMAX) : {ACC_WIDTH{1'b1}};
    assign acc_next[c] = sat_q[c] ? acc[c] : (sat_hit ? sat_val : wsum);
    assign sat_next[c] = sat_q[c] | sat_hit;
`else
    assign acc_next[c] = wsum;
`endif
  end

  assign beat_acc  = (state == S_ACCUM) && bus.psum_valid && psum_ready_q;
  assign last_beat = ((beat_cnt + 1'b1) == count_q);
  assign col_nxt   = col + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      for (int c = 0; c < ARRAY_SIZE; c++) acc[c] <= '0;
      beat_cnt     <= '0;
      count_q      <= '0;
      signed_q     <= 1'b0;
      col          <= '0;
      psum_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_col_q    <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PSUM_ACC_SAT_EN
      sat_q        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && (bus.acc_count != '0)) begin
            for (int c = 0; c < ARRAY_SIZE; c++) acc[c] <= '0;
`ifdef PSUM_ACC_SAT_EN
            sat_q        <= '0;
`endif
            count_q      <= bus.acc_count;
            signed_q     <= bus.signed_mode;
            beat_cnt     <= '0;
            psum_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            state        <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat_acc) begin
            for (int c = 0; c < ARRAY_SIZE; c++) acc[c] <= acc_next[c];
`ifdef PSUM_ACC_SAT_EN
            sat_q    <= sat_next;
`endif
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              // Column 0 is presented from the freshly summed value so DRAIN starts with valid data.
              psum_ready_q <= 1'b0;
              out_valid_q  <= 1'b1;
              out_data_q   <= acc_next[0];
              out_col_q    <= '0;
              out_last_q   <= (LAST_COL == '0);
              col          <= '0;
              state        <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            if (col == LAST_COL) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_col_q   <= '0;
              col         <= '0;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              state       <= S_IDLE;
            end else begin
              col         <= col_nxt;
              out_col_q   <= col_nxt;
              out_data_q  <= acc[col_nxt];
              out_last_q  <= (col_nxt == LAST_COL);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.psum_ready = psum_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule
